control: RTL and testbench

//  Main instruction decoder of the pipelined microprocessor.

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/control_decode.sv | 48 ++++
 rtl/control.sv | 39 +++
 tb/tb_control.sv | 73 +++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, ALU-op and control-bundle definitions shared by the decoder and its register stage
package ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LOAD  = 6'd1;
    localparam logic [5:0] OP_STORE = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd3;
    localparam logic [5:0] OP_ADDI  = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } mem_t;

    typedef struct packed {
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
    } calc_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode to control-bundle lookup
module control_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opCode,
    output wb_t        o_wb,
    output mem_t       o_mem,
    output calc_t      o_calc
);
    // Undefined or unknown opcodes fall to the default arm and decode as a NOP
    always_comb begin
        o_wb   = '0;
        o_mem  = '0;
        o_calc = '0;
        case (opCode)
            OP_RTYPE: begin
                o_calc = '{reg_dst: 1'b1, alu_op: ALUOP_FUNCT, alu_src: 1'b0};
                o_wb   = '{reg_write: 1'b1, mem_to_reg: 1'b0};
            end
            OP_LOAD: begin
                o_calc = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
                o_mem  = '{branch: 1'b0, mem_read: 1'b1, mem_write: 1'b0};
                o_wb   = '{reg_write: 1'b1, mem_to_reg: 1'b1};
            end
            OP_STORE: begin
                o_calc = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
                o_mem  = '{branch: 1'b0, mem_read: 1'b0, mem_write: 1'b1};
            end
            OP_BEQ: begin
                o_calc = '{reg_dst: 1'b0, alu_op: ALUOP_SUB, alu_src: 1'b0};
                o_mem  = '{branch: 1'b1, mem_read: 1'b0, mem_write: 1'b0};
            end
            OP_ADDI: begin
                o_calc = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
                o_wb   = '{reg_write: 1'b1, mem_to_reg: 1'b0};
            end
            OP_ORI: begin
                o_calc = '{reg_dst: 1'b0, alu_op: ALUOP_IMM, alu_src: 1'b1};
                o_wb   = '{reg_write: 1'b1, mem_to_reg: 1'b0};
            end
            default: begin
                o_wb   = '0;
                o_mem  = '0;
                o_calc = '0;
            end
        endcase
    end
endmodule

// File: rtl/control.sv
// control: main instruction decoder; registers the WB/MEM/EX control bundles into ID/EX
module control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opCode,
    output logic [1:0] writeBackControl,
    output logic [2:0] memAccessControl,
    output logic [3:0] calculationControl
);
    wb_t   w_wb,   r_wb;
    mem_t  w_mem,  r_mem;
    calc_t w_calc, r_calc;

    control_decode u_decode (
        .opCode (opCode),
        .o_wb   (w_wb),
        .o_mem  (w_mem),
        .o_calc (w_calc)
    );

    // Reset injects a bubble into the pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb   <= '0;
            r_mem  <= '0;
            r_calc <= '0;
        end else begin
            r_wb   <= w_wb;
            r_mem  <= w_mem;
            r_calc <= w_calc;
        end
    end

    assign writeBackControl   = r_wb;
    assign memAccessControl   = r_mem;
    assign calculationControl = r_calc;
endmodule

// File: tb/tb_control.sv
// tb_control: randomized and directed checks of control against a decode-table reference model
module tb_control;
    logic       clk;
    logic       rst;
    logic [5:0] opCode;
    logic [1:0] writeBackControl;
    logic [2:0] memAccessControl;
    logic [3:0] calculationControl;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] tbl [64];
    logic [8:0] exp_q;

    control dut (
        .clk                (clk),
        .rst                (rst),
        .opCode             (opCode),
        .writeBackControl   (writeBackControl),
        .memAccessControl   (memAccessControl),
        .calculationControl (calculationControl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference, then compare mid-cycle
    task automatic step(input logic r, input logic [5:0] op, input string tag);
        rst    = r;
        opCode = op;
        @(posedge clk);
        exp_q = r ? tbl[op] : 9'd0;
        @(negedge clk);
        check(tag, {calculationControl, memAccessControl, writeBackControl}, exp_q);
        check({tag, "_rdwr"}, {8'd0, memAccessControl[1] & memAccessControl[0]}, 9'd0);
        check({tag, "_brwr"}, {8'd0, memAccessControl[2] & writeBackControl[1]}, 9'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbl[i] = 9'd0;
        tbl[0] = {4'b1100, 3'b000, 2'b10};
        tbl[1] = {4'b0001, 3'b010, 2'b11};
        tbl[2] = {4'b0001, 3'b001, 2'b00};
        tbl[3] = {4'b0010, 3'b100, 2'b00};
        tbl[4] = {4'b0001, 3'b000, 2'b10};
        tbl[5] = {4'b0111, 3'b000, 2'b10};
        rst    = 1'b0;
        opCode = 6'd3;
        step(1'b0, 6'd3, "rst0");
        step(1'b0, 6'd3, "rst1");
        step(1'b1, 6'd3, "beq_after_rst");
        for (int i = 0; i < 6; i++) step(1'b1, 6'(i), $sformatf("op%0d", i));
        for (int i = 6; i < 64; i++) step(1'b1, 6'(i), $sformatf("undef%0d", i));
        step(1'b1, 6'd0, "stream_a");
        step(1'b0, 6'd0, "mid_rst");
        step(1'b1, 6'd1, "resume_load");
        step(1'b1, 6'd5, "resume_ori");
        for (int i = 0; i < 1000; i++)
            step($urandom_range(0, 19) != 0, 6'($urandom_range(0, 63)), "rand");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
